// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS: steps the tuning word from a start
// value to a stop value, holding each word for a programmable dwell.
// Modes: single up-sweep, continuous sawtooth, or continuous triangle.
//
// Ports:
//   clk, rst_n          sample clock (rising edge), async active-low reset
//   start, abort        sweep request (IDLE only), synchronous stop (any state)
//   cfg_mode            00 single, 01 sawtooth, 10 triangle, 11 as 00
//   cfg_start_ftw       first tuning word
//   cfg_stop_ftw        last tuning word
//   cfg_step            tuning-word increment per step
//   cfg_dwell           extra hold cycles per tuning word
//   ftw                 tuning word to the phase accumulator
//   phase_clr           one-cycle accumulator clear at sweep start
//   out_en, busy        DAC enable / sweep in progress (identical)
//   done                one-cycle pulse at the end of a single sweep
//   err                 one-cycle pulse when start is rejected (start > stop)
module dds_sweep_ctrl #(
  parameter int unsigned FTW_W   = 16,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_mode,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [FTW_W-1:0]   ftw,
  output logic               phase_clr,
  output logic               out_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, DWELL, STEP, FINISH} state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [FTW_W-1:0]     start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d, cnt_q, cnt_d;
  logic                 dir_down_q, dir_down_d;
  logic [FTW_W-1:0]     ftw_d;
  logic                 phase_clr_d, busy_d, done_d, err_d;

  logic [FTW_W:0]       up_sum;
  logic [FTW_W-1:0]     up_next, down_next;
  logic                 leg_end;

  // Clamped next words in each direction; the extra sum bit stops wrap past 2^FTW_W.
  always_comb begin
    up_sum    = {1'b0, ftw} + {1'b0, step_q};
    up_next   = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[FTW_W-1:0];
    // ftw never drops below start_q, so ftw - start_q cannot underflow
    down_next = ((ftw - start_q) < step_q) ? start_q : (ftw - step_q);
    // a zero step can never reach the far end, so it ends every leg at once
    leg_end   = (step_q == '0) || (dir_down_q ? (ftw == start_q) : (ftw == stop_q));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    dir_down_d  = dir_down_q;
    ftw_d       = ftw;
    busy_d      = busy;
    phase_clr_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      ftw_d      = '0;
      busy_d     = 1'b0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_d  = (cfg_mode == 2'b11) ? MODE_SINGLE : cfg_mode;
            start_d = cfg_start_ftw;
            stop_d  = cfg_stop_ftw;
            step_d  = cfg_step;
            dwell_d = cfg_dwell;
            if (cfg_start_ftw > cfg_stop_ftw) begin
              err_d = 1'b1;
            end else begin
              state_d     = DWELL;
              ftw_d       = cfg_start_ftw;
              phase_clr_d = 1'b1;
              busy_d      = 1'b1;
              dir_down_d  = 1'b0;
              cnt_d       = cfg_dwell;
            end
          end
        end
        DWELL: begin
          if (cnt_q == '0) state_d = STEP;
          else             cnt_d   = cnt_q - DWELL_W'(1);
        end
        STEP: begin
          state_d = DWELL;
          cnt_d   = dwell_q;
          if (!leg_end) begin
            ftw_d = dir_down_q ? down_next : up_next;
          end else begin
            case (mode_q)
              MODE_SAW: ftw_d = start_q;
              MODE_TRI: begin
                // turn around and take the first step of the new leg now
                dir_down_d = ~dir_down_q;
                ftw_d      = dir_down_q ? up_next : down_next;
              end
              default: begin
                state_d = FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      ftw        <= '0;
      phase_clr  <= 1'b0;
      out_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      ftw        <= ftw_d;
      phase_clr  <= phase_clr_d;
      out_en     <= busy_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FTW_W, default 16, width of tuning word; matches DDS phase accumulator width.
REQ-002 Parameter DWELL_W, default 24, width of dwell counter.
REQ-003 Port clk  input  1  system clock; the DDS sample clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 Port abort  input  1  synchronous stop; effective in every state.
REQ-007 Port cfg_mode  input  2  00 single up-sweep, 01 continuous sawtooth, 10 continuous triangle, 11 reserved (treated as 00).
REQ-008 Port cfg_start_ftw  input  FTW_W  first tuning word.
REQ-009 Port cfg_stop_ftw  input  FTW_W  last tuning word.
REQ-010 Port cfg_step  input  FTW_W  tuning-word increment per step.
REQ-011 Port cfg_dwell  input  DWELL_W  extra cycles each tuning word is held.
REQ-012 Port ftw  output  FTW_W  tuning word added to the DDS phase accumulator every clk.
REQ-013 Port phase_clr  output  1  one-cycle pulse; DDS accumulator loads 0 that cycle.
REQ-014 Port out_en  output  1  DAC output enable; 1 exactly while busy.
REQ-015 Port busy  output  1  sweep in progress.
REQ-016 Port done  output  1  one-cycle pulse at normal completion of a single sweep.
REQ-017 Port err  output  1  one-cycle pulse when start is rejected for bad configuration.

Function
REQ-018 States: IDLE, DWELL, STEP, FINISH; all outputs registered.
REQ-019 In IDLE with start=1 and abort=0: latch all cfg_* inputs; config changes during a sweep have no effect.
REQ-020 If latched start_ftw > stop_ftw: stay IDLE, pulse err next cycle, busy stays 0.
REQ-021 Otherwise next cycle: ftw=start_ftw, phase_clr=1 for that cycle only, busy=out_en=1, direction=up, dwell counter=cfg_dwell, enter DWELL.
REQ-022 DWELL: decrement counter each cycle; at counter==0 enter STEP; each tuning word is thus held cfg_dwell+2 cycles (dwell+1 plus one STEP cycle).
REQ-023 STEP (up): sum computed in FTW_W+1 bits; if ftw==stop_ftw the leg ends, else ftw=min(ftw+step, stop_ftw) and counter reloads; return to DWELL.
REQ-024 STEP (down, triangle only): if ftw==start_ftw the leg ends, else ftw=max(ftw-step, start_ftw) without underflow.
REQ-025 Leg end, mode 00: enter FINISH; mode 01: ftw=start_ftw, no phase_clr, continue; mode 10: direction flips, next value computed per REQ-023/024 in the new direction in the same STEP cycle.
REQ-026 FINISH: done=1 one cycle, busy=out_en=0, ftw holds stop_ftw, then IDLE.
REQ-027 cfg_step==0: ftw never changes; mode 00 finishes after first dwell; modes 01/10 hold start_ftw until abort.
REQ-028 start_ftw==stop_ftw: single-tone; mode 00 finishes after one dwell.
REQ-029 abort=1 in any state: next cycle IDLE, ftw=0, busy=out_en=0, no done/err pulse; abort beats simultaneous start.
REQ-030 start while busy is ignored.

Reset
REQ-031 rst_n=0 immediately forces IDLE, ftw=0, phase_clr=0, out_en=0, busy=0, done=0, err=0, counter=0, direction=up, latched config=0.
REQ-032 Reset release mid-sweep does not resume; block waits in IDLE for start.

Verification
REQ-033 Mode 00, start=100, stop=130, step=10, dwell=1, pulse start -> ftw 100,110,120,130 each held 3 cycles, phase_clr on first cycle, done one cycle later, busy 0.
REQ-034 Mode 00, start=100, stop=125, step=10 -> ftw 100,110,120,125 then done (clamp).
REQ-035 Mode 10, start=0, stop=20, step=10, dwell=0 -> ftw 0,10,20,10,0,10,... until abort; abort -> ftw=0, busy=0 next cycle, no done.
REQ-036 Mode 01, start=0xFFF0, stop=0xFFFF, step=0x000C -> 0xFFF0,0xFFFC,0xFFFF,0xFFF0 (no overflow wrap, no phase_clr on restart).
REQ-037 start=50, stop=40 -> err one cycle, busy never 1; start and abort same cycle in IDLE -> no action.
REQ-038 rst_n low mid-DWELL -> all outputs 0 asynchronously; after release stays IDLE until start.
